demux2_stream: RTL and testbench
================================

Name: demux2_stream

Overview:
- Registered 1-to-2 demultiplexer: the receive-side counterpart of the 2:1 select cells.
- Steers each accepted input word to output lane 0 or lane 1 according to select S, sampled with the word.
- Each lane has a 2-entry buffer and its own valid/ready handshake, so a stalled lane never corrupts the other.
- Per-lane delivery counters support bring-up and bench checking.

Parameters:
- WIDTH, 8, data width of A, Z0, Z1.
- CNT_W, 4, width of per-lane delivered-word counters CNT0/CNT1.

Ports:
- CK  in  1  clock; all state updates on rising edge.
- RN  in  1  synchronous active-low reset, sampled on rising CK.
- A  in  WIDTH  input data word.
- S  in  1  lane select for A: 0 -> lane 0, 1 -> lane 1.
- A_VLD  in  1  A/S valid.
- A_RDY  out  1  block can accept A on this cycle.
- Z0  out  WIDTH  lane 0 head word.
- Z0_VLD  out  1  lane 0 word valid.
- Z0_RDY  in  1  lane 0 consumer ready.
- Z1  out  WIDTH  lane 1 head word.
- Z1_VLD  out  1  lane 1 word valid.
- Z1_RDY  in  1  lane 1 consumer ready.
- CNT0  out  CNT_W  lane 0 words delivered, modulo 2^CNT_W.
- CNT1  out  CNT_W  lane 1 words delivered, modulo 2^CNT_W.

Behaviour:
- Reset:
  - RN=0 at a rising CK empties both lane buffers and clears CNT0/CNT1 to 0.
  - After that edge: Z0/Z1 = 0, Z0_VLD/Z1_VLD = 0.
  - A_RDY = 0 whenever RN = 0, combinationally.
  - Reset mid-transfer discards all buffered words; no handshake completes on a reset edge.
- Input handshake:
  - A_RDY = RN & !full(lane S); combinational from S and buffer state.
  - A word is accepted at a rising edge where A_VLD & A_RDY; A and S are sampled together.
  - A_VLD held while A_RDY=0 requires A and S stable (source rule; bench asserts).
- Latency: a word accepted at edge t appears on Zs with Zs_VLD=1 after edge t (1-cycle latency) if lane s was empty; no combinational A->Z path.
- Lane buffer, per lane (2 entries, FIFO order):
  - States: EMPTY(0), ONE(1), FULL(2).
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push+pop -> ONE, new word becomes head.
  - FULL: pop -> ONE; no push possible, because A_RDY=0 for this lane even when a pop occurs in the same cycle (no pass-through).
  - Zs_VLD = state != EMPTY.
  - Zs = head word when valid, 0 when EMPTY.
  - Pop = Zs_VLD & Zs_RDY at rising edge.
  - Zs_RDY while EMPTY has no effect.
- Lanes are independent: a push to one lane and pops on both lanes may all occur in the same cycle.
- Counters:
  - CNTs increments by 1 on each lane-s pop.
  - Wraps from 2^CNT_W-1 to 0; no saturation or flag.
- Ordering: words to the same lane leave in acceptance order. There is no ordering relation between lanes.

Decomposition:
- Package demux2_pkg holds:
  - default WIDTH and CNT_W constants.
  - LANE_DEPTH = 2.
  - lane-select constants LANE0 = 0, LANE1 = 1.
  - buffer state encoding EMPTY/ONE/FULL (2-bit).
- Sub-module lane_fifo2: 2-entry FIFO with push/pop, full/valid flags, head output and CK/RN. Instantiated twice.
- Top level holds: A_RDY select logic, push-enable steering, and the two delivery counters.

Test Plan:
- Reset: drive RN=0 for 2 cycles with A_VLD=1 -> A_RDY=0, Z0_VLD=Z1_VLD=0, Z0=Z1=0, CNT0=CNT1=0. Release RN -> A_RDY=1 the next cycle.
- Basic steering: with Z0_RDY=Z1_RDY=1, send A=8'h3C,S=0 then A=8'hA5,S=1 -> Z0=3C valid one cycle after its accept edge; Z1=A5 one cycle later; CNT0=1, CNT1=1.
- Lane full / back-pressure: hold Z0_RDY=0, send 11,22,33 all with S=0 -> 11 and 22 accepted. A_RDY=0 while S=0. Then switch S=1 with A=44 -> A_RDY=1 and 44 delivered on Z1. Release Z0_RDY -> Z0 outputs 11 then 22.
- Push+pop in ONE state: lane 1 holds 55, Z1_RDY=1, push 66 to lane 1 in the same cycle -> state stays ONE, Z1=66 the next cycle, CNT1 increments by 1.
- Full with simultaneous pop: lane 0 FULL (77,88), Z0_RDY=1, A_VLD=1,S=0,A=99 -> A_RDY=0 that cycle and 99 not accepted. The next cycle A_RDY=1, 99 is accepted, and Z0 order is 77,88,99.
- Counter wrap and mid-operation reset:
  - Deliver 17 words to lane 0 -> CNT0 = 1 (wrapped via 15->0).
  - Then with both lanes non-empty, pulse RN=0 for one edge -> all buffers empty, CNT0=CNT1=0, and the discarded words never appear.

Source files
------------

// File: rtl/demux2_stream_pkg.sv
// rtl/demux2_stream_pkg.sv - shared constants and lane buffer state encoding
package demux2_pkg;
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_CNT_W  = 4;
  localparam int LANE_DEPTH = 2;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;
endpackage

// File: rtl/demux2_stream_if.sv
// rtl/demux2_stream_if.sv - input stream and two output lanes of the demux
interface demux2_stream_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic [WIDTH-1:0] A;
  logic             S;
  logic             A_VLD;
  logic             A_RDY;
  logic [WIDTH-1:0] Z0;
  logic             Z0_VLD;
  logic             Z0_RDY;
  logic [WIDTH-1:0] Z1;
  logic             Z1_VLD;
  logic             Z1_RDY;
  logic [CNT_W-1:0] CNT0;
  logic [CNT_W-1:0] CNT1;

  modport slave (
    input  A, S, A_VLD, Z0_RDY, Z1_RDY,
    output A_RDY, Z0, Z0_VLD, Z1, Z1_VLD, CNT0, CNT1
  );

  modport master (
    output A, S, A_VLD, Z0_RDY, Z1_RDY,
    input  A_RDY, Z0, Z0_VLD, Z1, Z1_VLD, CNT0, CNT1
  );
endinterface

// File: rtl/demux2_stream_lane_fifo2.sv
// rtl/demux2_stream_lane_fifo2.sv - 2-entry lane FIFO, head always in slot 0
module lane_fifo2
  import demux2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_head
);
  buf_state_t       r_state;
  buf_state_t       w_next_state;
  logic [WIDTH-1:0] r_mem0;
  logic [WIDTH-1:0] r_mem1;
  logic [WIDTH-1:0] w_mem0_next;
  logic [WIDTH-1:0] w_mem1_next;

  always_ff @(posedge CK) begin
    if (!RN) begin
      r_state <= EMPTY;
      r_mem0  <= '0;
      r_mem1  <= '0;
    end else begin
      r_state <= w_next_state;
      r_mem0  <= w_mem0_next;
      r_mem1  <= w_mem1_next;
    end
  end

  // Pops shift slot 1 forward so the head is always slot 0.
  always_comb begin
    w_next_state = r_state;
    w_mem0_next  = r_mem0;
    w_mem1_next  = r_mem1;
    case (r_state)
      EMPTY: begin
        if (i_push) begin
          w_next_state = ONE;
          w_mem0_next  = i_data;
        end
      end
      ONE: begin
        case ({i_push, i_pop})
          2'b10: begin
            w_next_state = FULL;
            w_mem1_next  = i_data;
          end
          2'b01: w_next_state = EMPTY;
          2'b11: w_mem0_next = i_data;
          default: w_next_state = ONE;
        endcase
      end
      FULL: begin
        if (i_pop) begin
          w_next_state = ONE;
          w_mem0_next  = r_mem1;
        end
      end
      default: w_next_state = EMPTY;
    endcase
  end

  assign o_full = (r_state == FULL);
  assign o_vld  = (r_state != EMPTY);
  assign o_head = o_vld ? r_mem0 : '0;
endmodule

// File: rtl/demux2_stream.sv
// rtl/demux2_stream.sv - registered 1:2 stream demux with per-lane buffers and counters
module demux2_stream
  import demux2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic            CK,
  input logic            RN,
  demux2_stream_if.slave bus
);
  logic             w_full0;
  logic             w_full1;
  logic             w_accept;
  logic             w_push0;
  logic             w_push1;
  logic             w_pop0;
  logic             w_pop1;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // No pass-through: a full lane refuses input even when it pops this cycle.
  assign bus.A_RDY = RN & ~((bus.S == LANE1) ? w_full1 : w_full0);
  assign w_accept  = bus.A_VLD & bus.A_RDY;
  assign w_push0   = w_accept & (bus.S == LANE0);
  assign w_push1   = w_accept & (bus.S == LANE1);
  assign w_pop0    = bus.Z0_VLD & bus.Z0_RDY;
  assign w_pop1    = bus.Z1_VLD & bus.Z1_RDY;

  lane_fifo2 #(.WIDTH(WIDTH)) u_lane0 (
    .CK     (CK),
    .RN     (RN),
    .i_push (w_push0),
    .i_data (bus.A),
    .i_pop  (w_pop0),
    .o_full (w_full0),
    .o_vld  (bus.Z0_VLD),
    .o_head (bus.Z0)
  );

  lane_fifo2 #(.WIDTH(WIDTH)) u_lane1 (
    .CK     (CK),
    .RN     (RN),
    .i_push (w_push1),
    .i_data (bus.A),
    .i_pop  (w_pop1),
    .o_full (w_full1),
    .o_vld  (bus.Z1_VLD),
    .o_head (bus.Z1)
  );

  always_ff @(posedge CK) begin
    if (!RN) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_pop0) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (w_pop1) r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  assign bus.CNT0 = r_cnt0;
  assign bus.CNT1 = r_cnt1;
endmodule

// File: tb/tb_demux2_stream.sv
// tb/tb_demux2_stream.sv - scoreboard bench for demux2_stream
module tb_demux2_stream;
  logic CK = 1'b0;
  logic RN = 1'b0;

  demux2_stream_if #(.WIDTH(8), .CNT_W(4)) bus ();

  demux2_stream #(.WIDTH(8), .CNT_W(4)) dut (
    .CK  (CK),
    .RN  (RN),
    .bus (bus)
  );

  always #5 CK = ~CK;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic [3:0] m_cnt0 = 4'd0;
  logic [3:0] m_cnt1 = 4'd0;
  logic       p_vld = 1'b0;
  logic       p_rdy = 1'b0;
  logic       p_s = 1'b0;
  logic [7:0] p_a = 8'h00;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard whenever a lane handshake is about to complete.
  always @(negedge CK) begin
    if (mon_en) begin
      if (!RN) begin
        exp0.delete();
        exp1.delete();
        m_cnt0 = 4'd0;
        m_cnt1 = 4'd0;
        chk("a_rdy_in_reset", 32'(bus.A_RDY), 32'd0);
      end else begin
        chk("cnt0", 32'(bus.CNT0), 32'(m_cnt0));
        chk("cnt1", 32'(bus.CNT1), 32'(m_cnt1));
        if (bus.Z0_VLD) begin
          if (exp0.size() == 0) chk("z0_unexpected", 32'(bus.Z0), 32'hFFFF_FFFF);
          else begin
            chk("z0_data", 32'(bus.Z0), 32'(exp0[0]));
            if (bus.Z0_RDY) begin
              void'(exp0.pop_front());
              m_cnt0 = m_cnt0 + 4'd1;
            end
          end
        end else chk("z0_idle_zero", 32'(bus.Z0), 32'd0);
        if (bus.Z1_VLD) begin
          if (exp1.size() == 0) chk("z1_unexpected", 32'(bus.Z1), 32'hFFFF_FFFF);
          else begin
            chk("z1_data", 32'(bus.Z1), 32'(exp1[0]));
            if (bus.Z1_RDY) begin
              void'(exp1.pop_front());
              m_cnt1 = m_cnt1 + 4'd1;
            end
          end
        end else chk("z1_idle_zero", 32'(bus.Z1), 32'd0);
      end
      if (p_vld && !p_rdy && bus.A_VLD)
        chk("src_stable", {23'd0, bus.S, bus.A}, {23'd0, p_s, p_a});
      p_vld = bus.A_VLD;
      p_rdy = bus.A_RDY;
      p_s   = bus.S;
      p_a   = bus.A;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge CK);
    #1;
  endtask

  // Present a word, wait (bounded) for acceptance, record the expected delivery.
  task automatic send(logic [7:0] a, logic s);
    bit done = 1'b0;
    bus.A = a;
    bus.S = s;
    bus.A_VLD = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CK);
      if (bus.A_RDY) begin
        @(posedge CK);
        #1;
        if (s) exp1.push_back(a);
        else exp0.push_back(a);
        done = 1'b1;
      end else begin
        @(posedge CK);
        #1;
      end
    end
    if (!done) chk("send_timeout", 32'(a), 32'hFFFF_FFFF);
    bus.A_VLD = 1'b0;
  endtask

  task automatic pulse_reset();
    RN = 1'b0;
    bus.A_VLD = 1'b0;
    tick(1);
    RN = 1'b1;
  endtask

  initial begin
    bus.A = 8'h00;
    bus.S = 1'b0;
    bus.A_VLD = 1'b1;
    bus.Z0_RDY = 1'b1;
    bus.Z1_RDY = 1'b1;
    RN = 1'b0;

    // Reset with A_VLD asserted
    @(posedge CK);
    mon_en = 1'b1;
    @(posedge CK);
    #1;
    @(negedge CK);
    chk("rst_a_rdy", 32'(bus.A_RDY), 32'd0);
    chk("rst_z0_vld", 32'(bus.Z0_VLD), 32'd0);
    chk("rst_z1_vld", 32'(bus.Z1_VLD), 32'd0);
    chk("rst_z0", 32'(bus.Z0), 32'd0);
    chk("rst_z1", 32'(bus.Z1), 32'd0);
    chk("rst_cnt0", 32'(bus.CNT0), 32'd0);
    chk("rst_cnt1", 32'(bus.CNT1), 32'd0);
    @(posedge CK);
    #1;
    RN = 1'b1;
    bus.A_VLD = 1'b0;
    @(negedge CK);
    chk("release_a_rdy", 32'(bus.A_RDY), 32'd1);
    tick(1);

    // Basic steering
    send(8'h3C, 1'b0);
    @(negedge CK);
    chk("lat_z0", {23'd0, bus.Z0_VLD, bus.Z0}, {23'd0, 1'b1, 8'h3C});
    tick(1);
    send(8'hA5, 1'b1);
    @(negedge CK);
    chk("lat_z1", {23'd0, bus.Z1_VLD, bus.Z1}, {23'd0, 1'b1, 8'hA5});
    tick(3);
    chk("basic_cnt0", 32'(bus.CNT0), 32'd1);
    chk("basic_cnt1", 32'(bus.CNT1), 32'd1);

    // Lane 0 back-pressure; lane 1 keeps flowing
    bus.Z0_RDY = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    bus.A = 8'h33;
    bus.S = 1'b0;
    bus.A_VLD = 1'b1;
    @(negedge CK);
    chk("full0_a_rdy_a", 32'(bus.A_RDY), 32'd0);
    tick(1);
    @(negedge CK);
    chk("full0_a_rdy_b", 32'(bus.A_RDY), 32'd0);
    chk("full0_head", 32'(bus.Z0), 32'h11);
    tick(1);
    bus.A_VLD = 1'b0;
    tick(1);
    bus.S = 1'b1;
    bus.A = 8'h44;
    @(negedge CK);
    chk("lane1_a_rdy", 32'(bus.A_RDY), 32'd1);
    tick(1);
    send(8'h44, 1'b1);
    tick(3);
    bus.Z0_RDY = 1'b1;
    tick(4);
    chk("bp_cnt0", 32'(bus.CNT0), 32'd3);
    chk("bp_cnt1", 32'(bus.CNT1), 32'd2);

    // Push and pop together on a lane holding one word
    bus.Z1_RDY = 1'b0;
    send(8'h55, 1'b1);
    bus.Z1_RDY = 1'b1;
    send(8'h66, 1'b1);
    @(negedge CK);
    chk("pp_z1", {23'd0, bus.Z1_VLD, bus.Z1}, {23'd0, 1'b1, 8'h66});
    chk("pp_cnt1", 32'(bus.CNT1), 32'd3);
    tick(3);
    chk("pp_cnt1_drained", 32'(bus.CNT1), 32'd4);

    // Full lane with a pop in the same cycle: no pass-through
    bus.Z0_RDY = 1'b0;
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    bus.Z0_RDY = 1'b1;
    bus.A = 8'h99;
    bus.S = 1'b0;
    bus.A_VLD = 1'b1;
    @(negedge CK);
    chk("fp_a_rdy_blocked", 32'(bus.A_RDY), 32'd0);
    tick(1);
    @(negedge CK);
    chk("fp_a_rdy_open", 32'(bus.A_RDY), 32'd1);
    @(posedge CK);
    #1;
    exp0.push_back(8'h99);
    bus.A_VLD = 1'b0;
    tick(4);
    chk("fp_cnt0", 32'(bus.CNT0), 32'd6);

    // Counter wrap after 17 deliveries
    pulse_reset();
    for (int i = 0; i < 17; i++) send(8'(8'hC0 + i), 1'b0);
    tick(3);
    chk("wrap_cnt0", 32'(bus.CNT0), 32'd1);
    chk("wrap_cnt1", 32'(bus.CNT1), 32'd0);

    // Mid-operation reset discards buffered words
    bus.Z0_RDY = 1'b0;
    bus.Z1_RDY = 1'b0;
    send(8'hE1, 1'b0);
    send(8'hE2, 1'b1);
    send(8'hE3, 1'b1);
    pulse_reset();
    @(negedge CK);
    chk("mrst_z0_vld", 32'(bus.Z0_VLD), 32'd0);
    chk("mrst_z1_vld", 32'(bus.Z1_VLD), 32'd0);
    chk("mrst_cnt0", 32'(bus.CNT0), 32'd0);
    chk("mrst_cnt1", 32'(bus.CNT1), 32'd0);
    bus.Z0_RDY = 1'b1;
    bus.Z1_RDY = 1'b1;
    tick(5);

    chk("sb0_empty", 32'(exp0.size()), 32'd0);
    chk("sb1_empty", 32'(exp1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
